// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multi-cycle multiply/divide unit producing the hi/lo pair
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_from_ALU,
    output logic [WIDTH-1:0] lo_from_ALU
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_a_q, neg_a_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_upper, div_trial;
    logic [2*WIDTH:0]   mul_next, div_shift, div_next;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & operand_a[WIDTH-1];
        b_neg     = is_signed & operand_b[WIDTH-1];
        mag_a     = a_neg ? -operand_a : operand_a;
        mag_b     = b_neg ? -operand_b : operand_b;

        // Multiply: {upper, multiplier} accumulator, add-then-shift-right
        mul_upper = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_upper, acc_q[WIDTH-1:0]} >> 1;

        // Divide: {remainder, dividend} accumulator, shift-left then trial subtract
        div_shift = acc_q << 1;
        div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, m_q};
        div_next  = (div_shift[2*WIDTH:WIDTH] >= {1'b0, m_q}) ?
                    {div_trial, div_shift[WIDTH-1:1], 1'b1} : div_shift;

        prod      = acc_q[2*WIDTH-1:0];
        prod_fix  = neg_res_q ? -prod : prod;
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        a_d       = a_q;
        m_d       = m_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = CALC;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(WIDTH);
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_a_d   = a_neg;
                    a_d       = operand_a;
                    m_d       = op[1] ? mag_b : mag_a;
                    acc_d     = {{(WIDTH+1){1'b0}}, op[1] ? mag_a : mag_b};
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                busy_d = 1'b1;
                acc_d  = is_div_q ? div_next : mul_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (m_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_a_q   ? -rem : rem;
                    lo_d = neg_res_q ? -quo : quo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            a_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            a_q       <= a_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi_from_ALU = hi_q;
    assign lo_from_ALU = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    int pc = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          tag;
        string       nm;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (a),
        .operand_b   (b),
        .busy        (busy),
        .done        (done),
        .hi_from_ALU (hi),
        .lo_from_ALU (lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) pc <= pc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.nm, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.nm, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.nm, "_latency"}, 64'(pc - e.tag), 64'd34);
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input bit expect_result);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (expect_result) begin
            e.hi  = eh;
            e.lo  = el;
            e.tag = pc;
            e.nm  = nm;
            sb.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
        op    = o ^ 2'b10;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_0001;
    endtask

    task automatic track(input string nm, input int inject);
        int bad = 0;
        for (int i = 1; i <= 33; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (i == inject) begin
                start = 1'b1;
                op    = 2'b01;
                a     = 32'h0000_0100;
                b     = 32'h0000_0100;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        check({nm, "_busy_window"}, 64'(bad), 64'd0);
        check({nm, "_done_cycle"}, 64'({busy, done}), 64'b01);
    endtask

    task automatic finish_op(input string nm);
        @(negedge clock);
        check({nm, "_done_pulse"}, 64'({busy, done}), 64'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clock);
        check("rst_busy_done", 64'({busy, done}), 64'b00);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        track("multu_max", 0);
        finish_op("multu_max");

        issue("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        track("mult_neg", 0);
        issue("mult_b2b", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);
        track("mult_b2b", 0);
        finish_op("mult_b2b");

        issue("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        track("div_neg", 0);
        finish_op("div_neg");

        issue("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        track("divu_100_7", 0);
        finish_op("divu_100_7");

        issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);
        track("div_ovf", 0);
        finish_op("div_ovf");

        issue("divu_zero", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        track("divu_zero", 0);
        finish_op("divu_zero");

        issue("multu_ignore", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
        track("multu_ignore", 5);
        finish_op("multu_ignore");
        repeat (5) @(negedge clock);

        issue("rst_abort", 2'b11, 32'hFFFF_0000, 32'd3, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy_done", 64'({busy, done}), 64'b00);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("abort_quiet", 64'(bad), 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS core.
- Produces the hi/lo pair consumed by the register-file/decode stage for mult, multu, div and divu.
- The decode stage reads the hi/lo pair later via mfhi/mflo.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits; iteration count = WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- op  input  2  operation select, equal to funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu.
- operand_a  input  WIDTH  rs value: multiplicand or dividend.
- operand_b  input  WIDTH  rt value: multiplier or divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo are newly valid in that cycle.
- hi_from_ALU  output  WIDTH  mult: upper product half; div: remainder.
- lo_from_ALU  output  WIDTH  mult: lower product half; div: quotient.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, hi_from_ALU=0, lo_from_ALU=0; internal accumulators cleared.
- Reset has priority over every other input.
- Reset asserted mid-operation aborts the operation:
  - no done pulse is produced;
  - hi/lo are cleared.
- States and transitions:
  - IDLE: start=1 latches op and operands, goes to CALC, loads counter=WIDTH.
  - CALC: one iteration per cycle; counter decrements; counter reaching 0 goes to FIX.
  - FIX: applies sign correction, writes hi/lo registers, goes to DONE.
  - DONE: done=1 for exactly this cycle; start=1 here is accepted like in IDLE (goes to CALC); otherwise returns to IDLE.
- Timing, with start sampled in cycle 0:
  - busy=1 in cycles 1..WIDTH+1 (33 cycles for WIDTH=32);
  - done=1 and new hi/lo visible in cycle WIDTH+2 (cycle 34);
  - busy=0 in IDLE and DONE.
- start while busy=1 is ignored: no queuing, no effect on the running operation.
- hi/lo hold their last result until the next FIX or reset.
- Operands are latched at start; later operand changes have no effect.
- Signed ops (mult, div):
  - the magnitudes |a| and |b| are taken as WIDTH-bit unsigned values; 0x80000000 maps to 2^31.
  - the core computes unsigned on the magnitudes; FIX corrects signs as below.
- Multiply:
  - shift-add into a 2*WIDTH-bit product, one multiplier bit per CALC cycle.
  - mult: product negated (two's complement, 2*WIDTH bits) when the operand signs differ.
  - {hi,lo} = product.
- Divide:
  - restoring division, one quotient bit per CALC cycle.
  - div: quotient negated when the operand signs differ.
  - div: remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
- Divide by zero (div or divu):
  - lo = all ones, hi = operand_a (unmodified, no sign processing).
  - Same latency as a normal operation; no exception raised.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- op does not change during an operation (latched copy is used).

Test Plan:
- Unsigned multiply: multu 0xFFFFFFFF x 0xFFFFFFFF, start at cycle 0 -> busy cycles 1..33, done pulse at cycle 34 only, hi=0xFFFFFFFE, lo=0x00000001.
- Signed multiply: mult 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; back-to-back start in the DONE cycle with mult 5 x 6 -> hi=0, lo=30 after a further 34 cycles.
- Division:
  - div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 100/7 -> lo=14, hi=2.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: divu 0x00001234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234, done at cycle 34.
- start ignored while busy: start pulsed at cycle 5 with different operands during a running multu 3 x 4 -> result hi=0, lo=12, exactly one done pulse.
- Reset mid-operation: reset at cycle 10 of a divu -> next cycle busy=0, done=0, hi=lo=0; no done pulse appears afterwards.
